// File: rtl/sigdelay_pkg.sv
// Shared types and helpers for the sigdelay_fx delay/echo effect.
package sigdelay_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    DELAY    = 2'd1,
    ECHO     = 2'd2,
    FEEDBACK = 2'd3
  } mode_t;

  // Callers pass operands already bounded by max_val, so the 33-bit sum
  // never loses its carry and the clamp matches a D_WIDTH+1 saturating add.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sigdelay_fx_if.sv
// Sample stream bus between a driver and the sigdelay_fx effect block.
interface sigdelay_fx_if #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
);
  logic               en;
  logic [A_WIDTH-1:0] delay;
  logic [1:0]         mode;
  logic [2:0]         gain_shift;
  logic [D_WIDTH-1:0] mic_signal;
  logic [D_WIDTH-1:0] out_signal;
  logic               out_valid;
  logic               primed;

  modport master (
    output en, delay, mode, gain_shift, mic_signal,
    input  out_signal, out_valid, primed
  );

  modport slave (
    input  en, delay, mode, gain_shift, mic_signal,
    output out_signal, out_valid, primed
  );
endinterface

// File: rtl/delay_ram.sv
// Simple dual-port history RAM: one write port, one registered read port.
module delay_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               re,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  // Same-address read/write returns the old word; the top forwards around it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sigdelay_fx.sv
// Two-stage delay / echo / feedback effect over a circular sample history.
module sigdelay_fx
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  sigdelay_fx_if.slave bus
);

  localparam logic [31:0] MAX_SAMPLE = 32'((64'd1 << D_WIDTH) - 64'd1);

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] fill;
  logic [A_WIDTH-1:0] delay_q;
  logic [A_WIDTH-1:0] d_eff;
  logic [A_WIDTH-1:0] d_eff_q;
  logic [A_WIDTH-1:0] rd_addr;
  logic               take;
  logic               hist_ok;

  logic               s2_valid;
  logic [D_WIDTH-1:0] s2_mic;
  mode_t              s2_mode;
  logic [2:0]         s2_gain;
  logic [A_WIDTH-1:0] s2_ptr;
  logic               s2_primed;
  logic               fwd_hit;
  logic [D_WIDTH-1:0] fwd_data;

  logic               ram_we;
  logic [D_WIDTH-1:0] ram_rd_data;
  logic [D_WIDTH-1:0] dly_raw;
  logic [D_WIDTH-1:0] dly;
  logic [D_WIDTH-1:0] echo;
  logic [D_WIDTH-1:0] mix;
  logic [D_WIDTH-1:0] out_next;
  logic [D_WIDTH-1:0] wr_data;

  assign take    = bus.en && !rst;
  assign d_eff   = (bus.delay == '0) ? A_WIDTH'(1) : bus.delay;
  assign d_eff_q = (delay_q == '0) ? A_WIDTH'(1) : delay_q;
  assign rd_addr = wr_ptr - d_eff;
  // Masking uses the delay arriving with this sample so a longer delay
  // requested mid-stream never exposes slots written before reset.
  assign hist_ok = (fill >= d_eff);

  assign bus.primed = (fill >= d_eff_q);

  delay_ram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (s2_ptr),
    .wr_data (wr_data),
    .re      (take),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  assign ram_we = s2_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill     <= '0;
      delay_q  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= bus.en;
      if (bus.en) begin
        wr_ptr  <= wr_ptr + A_WIDTH'(1);
        delay_q <= bus.delay;
        if (fill != '1) begin
          fill <= fill + A_WIDTH'(1);
        end
      end
    end
  end

  // Stage-1 capture; the forward flag catches the d_eff=1 back-to-back case
  // where this read hits the slot stage 2 is writing on the same edge.
  always_ff @(posedge clk) begin
    if (take) begin
      s2_mic    <= bus.mic_signal;
      s2_mode   <= mode_t'(bus.mode);
      s2_gain   <= bus.gain_shift;
      s2_ptr    <= wr_ptr;
      s2_primed <= hist_ok;
      fwd_hit   <= s2_valid && (s2_ptr == rd_addr);
      fwd_data  <= wr_data;
    end
  end

  always_comb begin
    dly_raw  = fwd_hit ? fwd_data : ram_rd_data;
    dly      = s2_primed ? dly_raw : '0;
    echo     = dly >> s2_gain;
    mix      = D_WIDTH'(sat_add(32'(s2_mic), 32'(echo), MAX_SAMPLE));
    out_next = mix;
    wr_data  = s2_mic;
    case (s2_mode)
      BYPASS:   out_next = s2_mic;
      DELAY:    out_next = dly;
      ECHO:     out_next = mix;
      FEEDBACK: begin
        out_next = mix;
        wr_data  = mix;
      end
      default:  out_next = mix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_signal <= '0;
      bus.out_valid  <= 1'b0;
    end else begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_signal <= out_next;
      end
    end
  end

endmodule
